// File: rtl/sa48_operand_feeder_if.sv
// Operand handshake and 12-bit slice bus between the SA48 operand feeder and its producer/datapath.
// abort is not carried here; it is a separate scalar port on the feeder when SA48_ABORT_EN is defined.
interface sa48_operand_feeder_if #(
    parameter int WORD_W  = 48,
    parameter int SLICE_W = 12
);
    logic               start;
    logic [WORD_W-1:0]  opA;
    logic [WORD_W-1:0]  opB;
    logic               ready;
    logic               busy;
    logic [SLICE_W-1:0] outBusA;
    logic [SLICE_W-1:0] outBusB;
    logic               init0;
    logic               shift_12bR;
    logic               done;

    modport master (
        output start, opA, opB,
        input  ready, busy, outBusA, outBusB, init0, shift_12bR, done
    );

    modport slave (
        input  start, opA, opB,
        output ready, busy, outBusA, outBusB, init0, shift_12bR, done
    );
endinterface

// File: rtl/sa48_operand_feeder.sv
// SA48 operand feeder: latches two operands, then drives init0 and LSB-first slices to the datapath.
// Optional macro SA48_ABORT_EN adds an abort input that clears the datapath and returns to IDLE.
//
// state | meaning
// IDLE  | ready for a new operand pair
// INIT  | init0 strobe, datapath clear
// SHIFT | one slice per cycle on outBusA/outBusB
// DONE  | datapath result valid, done pulse
module sa48_operand_feeder #(
    parameter int WORD_W  = 48,
    parameter int SLICE_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef SA48_ABORT_EN
    input  logic                    abort,
`endif
    sa48_operand_feeder_if.slave    bus
);
    localparam int NSLICES = WORD_W / SLICE_W;
    localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WORD_W-1:0]  reg_a;
    logic [WORD_W-1:0]  reg_b;
    logic [WORD_W-1:0]  reg_a_nxt;
    logic [WORD_W-1:0]  reg_b_nxt;
    logic               abort_req;

    logic               ready_q;
    logic               busy_q;
    logic               init0_q;
    logic               shift_q;
    logic               done_q;
    logic [SLICE_W-1:0] out_a_q;
    logic [SLICE_W-1:0] out_b_q;

    always_comb begin
        reg_a_nxt = reg_a >> SLICE_W;
        reg_b_nxt = reg_b >> SLICE_W;
`ifdef SA48_ABORT_EN
        abort_req = abort && (state == INIT || state == SHIFT);
`else
        abort_req = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            reg_a   <= '0;
            reg_b   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            init0_q <= 1'b0;
            shift_q <= 1'b0;
            done_q  <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else if (abort_req) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            init0_q <= 1'b0;
            shift_q <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        reg_a   <= bus.opA;
                        reg_b   <= bus.opB;
                        state   <= INIT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        init0_q <= 1'b1;
                    end
                end
                INIT: begin
                    cnt     <= '0;
                    state   <= SHIFT;
                    init0_q <= 1'b0;
                    shift_q <= 1'b1;
                    out_a_q <= reg_a[SLICE_W-1:0];
                    out_b_q <= reg_b[SLICE_W-1:0];
                end
                SHIFT: begin
                    // Bus registers are loaded with the slice that becomes LSB after this shift.
                    reg_a <= reg_a_nxt;
                    reg_b <= reg_b_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(NSLICES - 1)) begin
                        state   <= DONE;
                        shift_q <= 1'b0;
                        done_q  <= 1'b1;
                        out_a_q <= '0;
                        out_b_q <= '0;
                    end else begin
                        out_a_q <= reg_a_nxt[SLICE_W-1:0];
                        out_b_q <= reg_b_nxt[SLICE_W-1:0];
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Abort must clear the datapath in the same cycle it is seen, so it bypasses the strobe registers.
    assign bus.init0      = init0_q | abort_req;
    assign bus.shift_12bR = shift_q & ~abort_req;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.outBusA    = out_a_q;
    assign bus.outBusB    = out_b_q;
endmodule

// File: tb/tb_sa48_operand_feeder.sv
// Directed bench for sa48_operand_feeder with a behavioural SA48 serial-add datapath attached.
// Covers the SA48_ABORT_EN build as well when that macro is defined.
module tb_sa48_operand_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SA48_ABORT_EN
    logic abort = 1'b0;
`endif
    int n_chk  = 0;
    int n_pass = 0;

    sa48_operand_feeder_if #(.WORD_W(48), .SLICE_W(12)) bus ();

    sa48_operand_feeder #(.WORD_W(48), .SLICE_W(12)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef SA48_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: 12-bit adder with carry, result register filled from the top.
    logic [47:0] dp_acc;
    logic        dp_c;
    logic [12:0] dp_sum;
    assign dp_sum = {1'b0, bus.outBusA} + {1'b0, bus.outBusB} + {12'd0, dp_c};

    always @(posedge clk) begin
        if (rst || bus.init0) begin
            dp_acc <= '0;
            dp_c   <= 1'b0;
        end else if (bus.shift_12bR) begin
            dp_acc <= {dp_sum[11:0], dp_acc[47:12]};
            dp_c   <= dp_sum[12];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, " ready"}, 64'(bus.ready), 64'd1);
        check_val({tag, " busy"},  64'(bus.busy), 64'd0);
        check_val({tag, " strobes"}, 64'({bus.init0, bus.shift_12bR, bus.done}), 64'd0);
        check_val({tag, " buses"}, 64'({bus.outBusA, bus.outBusB}), 64'd0);
    endtask

    // Entered at a negedge in IDLE; returns at the negedge of cycle 7 (IDLE again).
    task automatic run_op(input string tag, input logic [47:0] a, input logic [47:0] b,
                          input logic [47:0] exp_sum, input logic [11:0] exp_sa[4],
                          input logic [11:0] exp_sb[4], input bit hold_start);
        bus.start = 1'b1;
        bus.opA   = a;
        bus.opB   = b;
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        check_val({tag, " c1 init0"}, 64'(bus.init0), 64'd1);
        check_val({tag, " c1 ready/busy/shift"}, 64'({bus.ready, bus.busy, bus.shift_12bR}), 64'b010);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val($sformatf("%s shift%0d strobes", tag, k),
                      64'({bus.shift_12bR, bus.init0, bus.done}), 64'b100);
            check_val($sformatf("%s shift%0d busA", tag, k), 64'(bus.outBusA), 64'(exp_sa[k]));
            check_val($sformatf("%s shift%0d busB", tag, k), 64'(bus.outBusB), 64'(exp_sb[k]));
        end
        @(negedge clk);
        check_val({tag, " c6 done"}, 64'({bus.done, bus.shift_12bR, bus.ready}), 64'b100);
        check_val({tag, " c6 result"}, 64'(dp_acc), 64'(exp_sum));
        @(negedge clk);
        check_val({tag, " c7 ready"}, 64'({bus.ready, bus.busy, bus.done}), 64'b100);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.opA   = '0;
        bus.opB   = '0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.opA = 48'hABCDEF012345;
            bus.opB = 48'h55AA55AA55AA;
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end

        run_op("single", 48'h000000000FFF, 48'h000000000001, 48'h000000001000,
               '{12'hFFF, 12'h000, 12'h000, 12'h000}, '{12'h001, 12'h000, 12'h000, 12'h000}, 1'b0);
        run_op("carry", 48'hFFFFFFFFFFFF, 48'h000000000001, 48'h000000000000,
               '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, '{12'h001, 12'h000, 12'h000, 12'h000}, 1'b0);

        // Back-to-back with start held: second operands change in the IDLE cycle between ops.
        run_op("b2b1", 48'h123456789ABC, 48'h111111111111, 48'h23456789ABCD,
               '{12'hABC, 12'h789, 12'h456, 12'h123}, '{12'h111, 12'h111, 12'h111, 12'h111}, 1'b1);
        run_op("b2b2", 48'h000000000001, 48'h000000000002, 48'h000000000003,
               '{12'h001, 12'h000, 12'h000, 12'h000}, '{12'h002, 12'h000, 12'h000, 12'h000}, 1'b0);

        // Reset during the 2nd shift cycle.
        bus.start = 1'b1;
        bus.opA   = 48'h0000000F0F0F;
        bus.opB   = 48'h000000010101;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rstmid shift2 busA", 64'(bus.outBusA), 64'h0F0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rstmid");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val($sformatf("rstmid no done %0d", i), 64'({bus.done, bus.busy}), 64'd0);
        end

`ifdef SA48_ABORT_EN
        // Abort during the 3rd shift cycle.
        bus.start = 1'b1;
        bus.opA   = 48'h000000000FFF;
        bus.opB   = 48'h000000000FFF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check_val("abort cycle init0", 64'(bus.init0), 64'd1);
        check_val("abort cycle shift", 64'(bus.shift_12bR), 64'd0);
        @(negedge clk);
        abort = 1'b0;
        check_val("abort next ready", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
        check_val("abort dp result", 64'(dp_acc), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("abort no done %0d", i), 64'(bus.done), 64'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sa48_operand_feeder.md
Name: sa48_operand_feeder

Overview:
- Producer side of the SA48 serial-add datapath's 12-bit slice interface.
- Accepts two 48-bit operands over a valid/ready handshake and latches them.
- Sequences the datapath: one init0 cycle, then four shift_12bR cycles presenting operand slices LSB-first on the 12-bit buses.
- Pulses done once the datapath's 48-bit result register holds the completed sum.

Parameters:
- WORD_W, 48, operand width; must be an integer multiple of SLICE_W.
- SLICE_W, 12, slice width; matches the datapath adder width.
- NSLICES, WORD_W/SLICE_W (4), derived localparam; number of shift cycles.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operand valid; request to begin an addition.
- opA  input  WORD_W  operand A; sampled only on the accept cycle.
- opB  input  WORD_W  operand B; sampled only on the accept cycle.
- ready  output  1  high in IDLE; start && ready = accept.
- busy  output  1  high in INIT, SHIFT and DONE.
- outBusA  output  SLICE_W  slice of A to the datapath; 0 outside SHIFT.
- outBusB  output  SLICE_W  slice of B to the datapath; 0 outside SHIFT.
- init0  output  1  datapath clear strobe.
- shift_12bR  output  1  datapath shift/accumulate strobe.
- done  output  1  one-cycle pulse; datapath result valid this cycle.

Behaviour:
- FSM states: IDLE, INIT, SHIFT, DONE. Slice counter cnt is 0..NSLICES-1.
- Operand registers regA and regB are WORD_W wide.
- Reset: rst high at a posedge gives state=IDLE, cnt=0, regA=regB=0. Outputs become ready=1, busy=0, done=0, init0=0, shift_12bR=0, outBusA=outBusB=0.
- rst overrides everything, including mid-operation. The operation is dropped, no done is issued, and the FSM returns to IDLE.
- All outputs decode from state and registers only; no combinational path from any input.
- IDLE: on start=1, latch regA=opA and regB=opB, then go to INIT. With start=0, stay in IDLE; opA and opB are ignored.
- INIT: init0=1 for exactly one cycle; cnt <= 0; next state SHIFT.
- SHIFT: shift_12bR=1, outBusA=regA[SLICE_W-1:0], outBusB=regB[SLICE_W-1:0].
  - Each cycle, regA and regB shift right by SLICE_W with zero fill, and cnt increments.
  - When cnt==NSLICES-1, the next state is DONE. SHIFT lasts exactly NSLICES cycles.
- DONE: done=1 for one cycle; next state IDLE. start is ignored in DONE; ready=0.
- Timing, with accept at edge E0:
  - init0 high during cycle 1.
  - shift_12bR high during cycles 2-5, slices 0..3.
  - done high during cycle 6.
  - ready high again in cycle 7.
  - Accept-to-done latency is NSLICES+2 cycles; initiation interval is NSLICES+3 cycles.
- init0 and shift_12bR are never high in the same cycle.
- start held continuously: back-to-back operations run with one IDLE cycle between them. The operands sampled are those present in each IDLE accept cycle.
- Carry handling stays in the datapath. The feeder never alters operand bits.

Optional Feature:
- Macro SA48_ABORT_EN.
- When defined, the block adds input port abort (1 bit).
  - abort=1 while in INIT or SHIFT: init0 is driven 1 in that cycle (clearing the datapath carry and result), shift_12bR=0, and the next state is IDLE. No done pulse.
  - abort in IDLE or DONE is ignored. rst has priority over abort.
- When not defined, there is no abort port and the behaviour is exactly as above.

Test Plan:
- Reset, then idle: check ready=1, busy=0, all strobes 0, outBusA=outBusB=0 for 5 cycles with start=0.
- Single add, opA=48'h000000000FFF, opB=48'h000000000001: outBusA sequence FFF,000,000,000 and outBusB sequence 001,000,000,000 on the four shift cycles. Paired with the SA48 datapath, its outBus=48'h000000001000 in the done cycle.
- Full carry chain, opA=48'hFFFFFFFFFFFF, opB=48'h000000000001: the datapath result is 48'h000000000000 at done. done occurs exactly 6 cycles after accept.
- Back-to-back, start held high with opA=48'h123456789ABC, opB=48'h111111111111, then opA=1, opB=2 changed in cycle 7: first result 48'h23456789ABCD, second result 48'h000000000003. One IDLE cycle between operations.
- Reset mid-operation (rst during the 2nd shift cycle): next cycle state=IDLE, ready=1, no done pulse, outBusA=0.
- SA48_ABORT_EN build, abort during the 3rd shift cycle: init0=1 in that cycle, no done pulse, ready=1 in the following cycle, and the datapath outBus is 0.
